alu_issue_ctrl: RTL

//   Initiator side of the 32-bit ALU func/operand interface. Accepts 16-bit register-form

---
 rtl/alu_issue_ctrl_pkg.sv | 36 +++
 rtl/alu_issue_ctrl_if.sv | 12 +
 rtl/alu_issue_ctrl_regfile.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: function codes, FSM encodings and
// the 16-bit register-form instruction layout.
package alu_issue_ctrl_pkg;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;
  localparam logic [3:0] FUNC_AND = 4'b0010;
  localparam logic [3:0] FUNC_OR  = 4'b0011;
  localparam logic [3:0] FUNC_XOR = 4'b0100;
  localparam logic [3:0] FUNC_NOT = 4'b0101;
  localparam logic [3:0] FUNC_SLL = 4'b0110;
  localparam logic [3:0] FUNC_SRA = 4'b0111;
  localparam logic [3:0] FUNC_SRL = 4'b1000;
  localparam logic [3:0] OP_MAX   = 4'd8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
  } instr_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Func/operand bus between the issue controller (master) and the registered ALU (slave).
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [3:0]        alu_func;
  logic [DATA_W-1:0] alu_out;

  modport master (output alu_in1, output alu_in2, output alu_func, input alu_out);
  modport slave  (input alu_in1, input alu_in2, input alu_func, output alu_out);
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// Operand register file: one synchronous write port, three asynchronous read ports,
// cleared synchronously on reset.
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] raddr_c,
  output logic [DATA_W-1:0] rdata_c
);
  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
  assign rdata_c = mem[raddr_c];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues register-form instructions to a one-cycle-latency ALU and writes results back.
//   state    | meaning
//   ST_IDLE  | accept instruction or cfg preload write
//   ST_ISSUE | operands/func presented, ALU samples at the end of this cycle
//   ST_CAPT  | alu_out valid, written back to rd at the end of this cycle
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  alu_issue_ctrl_if.master  alu,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err
);
  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_q;
  instr_t            dec;
  logic              is_idle;
  logic              is_capt;
  logic              accept;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  assign dec         = instr_t'(instr);
  assign is_idle     = (state == ST_IDLE);
  assign is_capt     = (state == ST_CAPT);
  assign instr_ready = is_idle && !cfg_we;
  assign accept      = instr_ready && instr_valid;

  // Writeback owns the single write port in CAPT; preload only lands while IDLE.
  assign rf_we    = is_capt || (is_idle && cfg_we);
  assign rf_waddr = is_capt ? rd_q : cfg_addr;
  assign rf_wdata = is_capt ? alu.alu_out : cfg_wdata;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (ADDR_W'(dec.rs)),
    .rdata_a (rs_data),
    .raddr_b (ADDR_W'(dec.rt)),
    .rdata_b (rt_data),
    .raddr_c (dbg_raddr),
    .rdata_c (dbg_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rd_q         <= '0;
      alu.alu_in1  <= '0;
      alu.alu_in2  <= '0;
      alu.alu_func <= FUNC_ADD;
      result       <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op_legal(dec.op)) begin
              alu.alu_in1  <= rs_data;
              alu.alu_in2  <= rt_data;
              alu.alu_func <= dec.op;
              rd_q         <= ADDR_W'(dec.rd);
              state        <= ST_ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_ISSUE: state <= ST_CAPT;
        ST_CAPT: begin
          result <= alu.alu_out;
          done   <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
